// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Issues one request/acknowledge bus transaction per aligned load/store,
// steers store bytes onto lanes, extracts and extends load data, stalls the
// pipeline while the access is outstanding and flags misaligned addresses.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no access outstanding; aligned access presented starts one
//   BUSY   | dm_req high, waiting for dm_ack
//   DONE   | result valid on mem_o_dmout, pipeline advances this cycle
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              mem_i_valid,
  input  logic              mem_i_rd,
  input  logic              mem_i_wr,
  input  logic [1:0]        mem_i_size,
  input  logic              mem_i_sext,
  input  logic [ADDR_W-1:0] mem_i_alures,
  input  logic [31:0]       mem_i_dmdin,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       mem_o_dmout,
  output logic              mem_o_stall,
  output logic              mem_o_adel,
  output logic              mem_o_ades
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_dmout;
  logic              r_load;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [1:0]        r_off;

  logic              w_access;
  logic              w_misal;
  logic              w_start;
  logic              w_idle;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  // rd wins over wr when both are set, so "load" is simply mem_i_rd
  assign w_access = mem_i_valid & (mem_i_rd | mem_i_wr);
  assign w_misal  = ((mem_i_size == 2'd1) & mem_i_alures[0]) |
                    (mem_i_size[1] & (mem_i_alures[1:0] != 2'b00));
  assign w_idle   = (r_state == S_IDLE);
  assign w_start  = w_idle & w_access & ~w_misal;

  // Byte-lane steering of the presented access (loads carry no write data)
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_i_dmdin;
    case (mem_i_size)
      2'd0: begin
        w_be    = 4'b0001 << mem_i_alures[1:0];
        w_wdata = {4{mem_i_dmdin[7:0]}};
      end
      2'd1: begin
        w_be    = mem_i_alures[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_i_dmdin[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_i_dmdin;
      end
    endcase
    if (mem_i_rd) begin
      w_wdata = 32'h0;
    end
  end

  // Lane extraction and extension of bus read data using the latched op info
  always_comb begin
    w_byte = dm_rdata[7:0];
    case (r_off)
      2'd0:    w_byte = dm_rdata[7:0];
      2'd1:    w_byte = dm_rdata[15:8];
      2'd2:    w_byte = dm_rdata[23:16];
      default: w_byte = dm_rdata[31:24];
    endcase
    w_half = r_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r_size)
      2'd0:    w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_ext = {{16{r_sext & w_half[15]}}, w_half};
      default: w_ext = dm_rdata;
    endcase
  end

  // State register
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DONE never starts a new access since the same
  // instruction is still presented
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (dm_ack)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus request registers, latched op info and the load result register
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_dmout <= 32'h0;
      r_load  <= 1'b0;
      r_size  <= 2'd0;
      r_sext  <= 1'b0;
      r_off   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= ~mem_i_rd;
            r_addr  <= {mem_i_alures[ADDR_W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_load  <= mem_i_rd;
            r_size  <= mem_i_size;
            r_sext  <= mem_i_sext;
            r_off   <= mem_i_alures[1:0];
          end
        end
        S_BUSY: begin
          if (dm_ack) begin
            r_req   <= 1'b0;
            r_dmout <= r_load ? w_ext : 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dm_req      = r_req;
  assign dm_we       = r_we;
  assign dm_addr     = r_addr;
  assign dm_be       = r_be;
  assign dm_wdata    = r_wdata;
  assign mem_o_dmout = r_dmout;

  // Status outputs are forced low while reset is held
  assign mem_o_stall = ~cpu_rst & (w_start | (r_state == S_BUSY));
  assign mem_o_adel  = ~cpu_rst & w_idle & w_access & w_misal & mem_i_rd;
  assign mem_o_ades  = ~cpu_rst & w_idle & w_access & w_misal & ~mem_i_rd;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit
// against a byte-arithmetic reference model.
module tb_mem_access_unit;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic        mem_i_valid;
  logic        mem_i_rd;
  logic        mem_i_wr;
  logic [1:0]  mem_i_size;
  logic        mem_i_sext;
  logic [31:0] mem_i_alures;
  logic [31:0] mem_i_dmdin;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] mem_o_dmout;
  logic        mem_o_stall;
  logic        mem_o_adel;
  logic        mem_o_ades;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_dmout = 32'h0;

  mem_access_unit #(.ADDR_W(32)) u_dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst      (cpu_rst),
    .mem_i_valid  (mem_i_valid),
    .mem_i_rd     (mem_i_rd),
    .mem_i_wr     (mem_i_wr),
    .mem_i_size   (mem_i_size),
    .mem_i_sext   (mem_i_sext),
    .mem_i_alures (mem_i_alures),
    .mem_i_dmdin  (mem_i_dmdin),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .mem_o_dmout  (mem_o_dmout),
    .mem_o_stall  (mem_o_stall),
    .mem_o_adel   (mem_o_adel),
    .mem_o_ades   (mem_o_ades)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: access width in bytes and the lane offset it occupies
  function automatic int m_nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic int m_off(input logic [1:0] size, input logic [31:0] addr);
    int n = m_nbytes(size);
    return (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic logic m_misal(input logic [1:0] size, input logic [31:0] addr);
    return (int'(addr[1:0]) % m_nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int n = m_nbytes(size);
    int v = ((1 << n) - 1) << m_off(size, addr);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] din);
    logic [31:0] w;
    int n = m_nbytes(size);
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = din[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] size,
                                         input logic sext, input logic [31:0] addr);
    int n = m_nbytes(size);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
    v = (rdata >> (8 * m_off(size, addr))) & mask;
    if (sext && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Presents one access in IDLE, answers with dm_ack in cycle k, checks every cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] size,
                            input logic sext, input logic [31:0] addr, input logic [31:0] din,
                            input logic [31:0] rdata, input int k);
    logic is_load;
    int   stalls;
    is_load = rd;
    stalls  = 0;
    mem_i_valid = 1'b1; mem_i_rd = rd; mem_i_wr = wr; mem_i_size = size;
    mem_i_sext = sext; mem_i_alures = addr; mem_i_dmdin = din;
    @(negedge cpu_clk_50M);
    if (m_misal(size, addr)) begin
      chk("adel", mem_o_adel, is_load);
      chk("ades", mem_o_ades, !is_load);
      chk("stall_mis", mem_o_stall, 0);
      @(posedge cpu_clk_50M); #1;
      chk("req_mis", dm_req, 0);
      chk("dmout_hold", mem_o_dmout, exp_dmout);
      mem_i_valid = 1'b0;
      return;
    end
    chk("adel_al", mem_o_adel, 0);
    chk("ades_al", mem_o_ades, 0);
    chk("req_c0", dm_req, 0);
    if (mem_o_stall) stalls++;
    @(posedge cpu_clk_50M); #1;
    for (int c = 1; c <= k; c++) begin
      if (c == k) begin
        dm_ack = 1'b1; dm_rdata = rdata;
      end else begin
        dm_rdata = $urandom;
      end
      @(negedge cpu_clk_50M);
      chk("req", dm_req, 1);
      chk("we", dm_we, !is_load);
      chk("addr", dm_addr, {addr[31:2], 2'b00});
      chk("be", dm_be, m_be(size, addr));
      chk("wdata", dm_wdata, is_load ? 32'h0 : m_wdata(size, din));
      chk("dmout_busy", mem_o_dmout, exp_dmout);
      if (mem_o_stall) stalls++;
      @(posedge cpu_clk_50M); #1;
      dm_ack = 1'b0;
    end
    exp_dmout = is_load ? m_load(rdata, size, sext, addr) : 32'h0;
    @(negedge cpu_clk_50M);
    chk("req_done", dm_req, 0);
    chk("stall_done", mem_o_stall, 0);
    chk("stall_cnt", stalls, k + 1);
    chk("dmout", mem_o_dmout, exp_dmout);
    @(posedge cpu_clk_50M); #1;
    chk("req_idle", dm_req, 0);
    mem_i_valid = 1'b0;
  endtask

  initial begin
    cpu_rst = 1'b1;
    mem_i_valid = 1'b0; mem_i_rd = 1'b0; mem_i_wr = 1'b0; mem_i_size = 2'd0;
    mem_i_sext = 1'b0; mem_i_alures = 32'h0; mem_i_dmdin = 32'h0;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    #5;
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_be", dm_be, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_dmout", mem_o_dmout, 0);
    chk("rst_stall", mem_o_stall, 0);
    repeat (2) @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
    @(posedge cpu_clk_50M); #1;

    // directed cases
    run_access(1, 0, 2'd2, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1);
    chk("tp_lw", mem_o_dmout, 32'hDEAD_BEEF);
    run_access(0, 1, 2'd0, 0, 32'h0000_0023, 32'h1234_56A5, 32'h0, 1);
    chk("tp_sb", mem_o_dmout, 32'h0);
    run_access(1, 0, 2'd1, 1, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 1);
    chk("tp_lhs", mem_o_dmout, 32'hFFFF_8001);
    run_access(1, 0, 2'd1, 0, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 2);
    chk("tp_lhu", mem_o_dmout, 32'h0000_8001);
    run_access(1, 0, 2'd0, 0, 32'h0000_0001, 32'h0, 32'h0000_F000, 3);
    chk("tp_lbu", mem_o_dmout, 32'h0000_00F0);
    run_access(0, 1, 2'd2, 0, 32'h0000_0002, 32'h5555_AAAA, 32'h0, 1);
    run_access(1, 1, 2'd3, 1, 32'h0000_0101, 32'h0, 32'h0, 1);
    run_access(1, 1, 2'd0, 1, 32'h0000_0103, 32'h0, 32'h8000_0000, 1);
    chk("tp_rdwins", mem_o_dmout, 32'hFFFF_FF80);

    // randomized accesses, with occasional idle (not presented) cycles
    for (int it = 0; it < 60; it++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op == 3) begin
        mem_i_valid = 1'($urandom_range(0, 1));
        mem_i_rd = 1'b0; mem_i_wr = 1'b0;
        mem_i_alures = $urandom;
        @(negedge cpu_clk_50M);
        chk("noacc_stall", mem_o_stall, 0);
        chk("noacc_adel", mem_o_adel, 0);
        @(posedge cpu_clk_50M); #1;
        chk("noacc_req", dm_req, 0);
        mem_i_valid = 1'b0;
      end else begin
        run_access(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, int'($urandom_range(1, 4)));
      end
    end

    // reset while BUSY, then a stray ack after release
    mem_i_valid = 1'b1; mem_i_rd = 1'b1; mem_i_wr = 1'b0; mem_i_size = 2'd2;
    mem_i_alures = 32'h0000_0040;
    @(posedge cpu_clk_50M); #1;
    chk("rst_busy_req", dm_req, 1);
    #2 cpu_rst = 1'b1;
    #1;
    chk("arst_req", dm_req, 0);
    chk("arst_stall", mem_o_stall, 0);
    chk("arst_dmout", mem_o_dmout, 0);
    @(posedge cpu_clk_50M); #1;
    mem_i_valid = 1'b0;
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
    exp_dmout = 32'h0;
    @(posedge cpu_clk_50M); #1;
    dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
    @(posedge cpu_clk_50M); #1;
    dm_ack = 1'b0;
    @(negedge cpu_clk_50M);
    chk("ack_ign_req", dm_req, 0);
    chk("ack_ign_dmout", mem_o_dmout, 0);
    chk("ack_ign_stall", mem_o_stall, 0);
    @(posedge cpu_clk_50M); #1;
    run_access(1, 0, 2'd2, 0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
